// File: rtl/mc_cpu_controller.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the 55-instruction MIPS datapath; strobes decode combinationally from state/i/flags.
// 2..4 cycles per instruction plus MEM_WAIT memory cycles or an open-ended MD stall on md_done; retired counts completed instructions.
module mc_cpu_controller #(
  parameter int NUM_INSTR    = 55,
  parameter int MEM_WAIT     = 1,
  parameter bit IRQ_EN       = 1'b0,
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_INSTR-1:0] i,
  input  logic                 z,
  input  logic                 neg,
  input  logic                 md_done,
  input  logic                 irq,
  input  logic                 ie,
  output logic                 ir_ena,
  output logic                 pc_ena,
  output logic [2:0]           pc_src,
  output logic                 rf_w,
  output logic                 dm_cs,
  output logic                 dm_r,
  output logic                 dm_w,
  output logic                 md_start,
  output logic                 hi_ena,
  output logic                 lo_ena,
  output logic                 exc,
  output logic [4:0]           cause,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MD  = 3'd5,
    S_EXC = 3'd6,
    S_RST = 3'd7
  } state_e;

  localparam int I_JR = 16, I_LW = 22, I_SW = 23, I_BEQ = 24, I_BNE = 25;
  localparam int I_J = 29, I_JAL = 30, I_DIVU = 32, I_ERET = 33, I_JALR = 34;
  localparam int I_LB = 35, I_LBU = 36, I_LHU = 37, I_SB = 38, I_SH = 39, I_LH = 40;
  localparam int I_MTC0 = 44, I_MTHI = 45, I_MTLO = 46, I_MULT = 47, I_MULTU = 48;
  localparam int I_SYSCALL = 49, I_TEQ = 50, I_BGEZ = 51, I_BREAK = 52, I_DIV = 53, I_MUL = 54;

  localparam logic [2:0] PC_SEQ = 3'd0, PC_BR = 3'd1, PC_JMP = 3'd2, PC_RS = 3'd3;
  localparam logic [2:0] PC_EXC = 3'd4, PC_EPC = 3'd5;

  localparam logic [4:0] C_INT = 5'b00000, C_SYS = 5'b01000, C_BRK = 5'b01001;
  localparam logic [4:0] C_RI  = 5'b01010, C_TR  = 5'b01101;

  localparam int              MW_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [MW_W-1:0] MW_LAST = MW_W'(MEM_WAIT - 1);

  state_e           state_q, state_d;
  logic [MW_W-1:0]  cnt_q, cnt_d;
  logic [4:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic one_hot, is_jump, is_branch, br_taken, is_md, is_load, is_store, is_mt;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign one_hot   = (i != '0) && ((i & (i - NUM_INSTR'(1))) == '0);
  assign is_jump   = i[I_J] | i[I_JAL] | i[I_JR] | i[I_JALR] | i[I_ERET];
  assign is_branch = i[I_BEQ] | i[I_BNE] | i[I_BGEZ];
  assign br_taken  = (i[I_BEQ] & z) | (i[I_BNE] & ~z) | (i[I_BGEZ] & ~neg);
  assign is_md     = i[I_MULT] | i[I_MULTU] | i[I_DIV] | i[I_DIVU] | i[I_MUL];
  assign is_load   = i[I_LW] | i[I_LB] | i[I_LBU] | i[I_LHU] | i[I_LH];
  assign is_store  = i[I_SW] | i[I_SB] | i[I_SH];
  assign is_mt     = i[I_MTC0] | i[I_MTHI] | i[I_MTLO];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    ir_ena    = 1'b0;
    pc_ena    = 1'b0;
    pc_src    = PC_SEQ;
    rf_w      = 1'b0;
    dm_cs     = 1'b0;
    dm_r      = 1'b0;
    dm_w      = 1'b0;
    md_start  = 1'b0;
    hi_ena    = 1'b0;
    lo_ena    = 1'b0;
    exc       = 1'b0;
    cause     = 5'd0;

    case (state_q)
      S_RST: state_d = S_IF;

      S_IF: begin
        if (IRQ_EN && irq && ie) begin
          cause_d = C_INT;
          state_d = S_EXC;
        end else begin
          ir_ena  = 1'b1;
          state_d = S_ID;
        end
      end

      S_ID: begin
        if (!one_hot) begin
          if (ILLEGAL_TRAP) begin
            cause_d = C_RI;
            state_d = S_EXC;
          end else begin
            pc_ena  = 1'b1;
            state_d = S_IF;
          end
        end else if (i[I_SYSCALL]) begin
          cause_d = C_SYS;
          state_d = S_EXC;
        end else if (i[I_BREAK]) begin
          cause_d = C_BRK;
          state_d = S_EXC;
        end else if (is_jump) begin
          pc_ena  = 1'b1;
          pc_src  = i[I_ERET] ? PC_EPC : ((i[I_JR] | i[I_JALR]) ? PC_RS : PC_JMP);
          rf_w    = i[I_JAL] | i[I_JALR];
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (is_branch) begin
          pc_ena  = 1'b1;
          pc_src  = br_taken ? PC_BR : PC_SEQ;
          state_d = S_IF;
        end else if (i[I_TEQ]) begin
          if (z) begin
            cause_d = C_TR;
            state_d = S_EXC;
          end else begin
            pc_ena  = 1'b1;
            state_d = S_IF;
          end
        end else if (is_md) begin
          md_start = 1'b1;
          state_d  = S_MD;
        end else if (is_load || is_store) begin
          cnt_d   = MW_LAST;
          state_d = S_MEM;
        end else if (is_mt) begin
          pc_ena  = 1'b1;
          hi_ena  = i[I_MTHI];
          lo_ena  = i[I_MTLO];
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dm_cs = 1'b1;
        dm_r  = is_load;
        // The counter is only reloaded in EX, so MW_LAST marks the first MEM cycle.
        dm_w  = is_store && (cnt_q == MW_LAST);
        if (cnt_q == '0) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_ena  = 1'b1;
            state_d = S_IF;
          end
        end else begin
          cnt_d = cnt_q - MW_W'(1);
        end
      end

      S_WB: begin
        rf_w    = 1'b1;
        pc_ena  = 1'b1;
        state_d = S_IF;
      end

      S_MD: begin
        if (md_done) begin
          hi_ena  = 1'b1;
          lo_ena  = 1'b1;
          rf_w    = i[I_MUL];
          pc_ena  = 1'b1;
          state_d = S_IF;
        end
      end

      S_EXC: begin
        exc     = 1'b1;
        cause   = cause_q;
        pc_ena  = 1'b1;
        pc_src  = PC_EXC;
        state_d = S_IF;
      end

      default: state_d = S_RST;
    endcase

    if (pc_ena && (state_q != S_EXC)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      cause_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
